complex_operand_packer: RTL and testbench

- Transmit side of the complex_matrix_mul operand interface.
- Accepts one complex operand quadruple per beat on a valid/ready stream (a_re, a_im, b_re, b_im, as IEEE-754 doubles) and assembles SIZE beats into the packed operands vector.
- Presents the vector to complex_matrix_mul with a valid/ready initiator handshake.
- Ping-pong double buffering lets the next vector fill while the current one waits for acceptance. Short vectors are zero-padded.

---
 rtl/complex_pkg.sv | 24 ++
 rtl/complex_operand_packer_if.sv | 33 +++
 rtl/complex_operand_packer_operand_bank.sv | 56 +++++
 rtl/complex_operand_packer.sv | 128 ++++++++++++
 tb/tb_complex_operand_packer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/complex_pkg.sv
// Shared constants and types for the complex operand path.
// Operand order within a beat: a_re, a_im, b_re, b_im.
package complex_pkg;

  localparam int unsigned FP64_WIDTH   = 64;
  localparam int unsigned NUM_OPERANDS = 4;

  localparam int unsigned OPERAND_A_RE = 0;
  localparam int unsigned OPERAND_A_IM = 1;
  localparam int unsigned OPERAND_B_RE = 2;
  localparam int unsigned OPERAND_B_IM = 3;

  localparam logic [FP64_WIDTH-1:0] FP64_ZERO = 64'h0;

  // One input beat: four FP64 operands
  typedef logic [NUM_OPERANDS-1:0][FP64_WIDTH-1:0] cplx_beat_t;

  // Write-side fill state
  typedef enum logic {
    WR_FILL  = 1'b0,
    WR_STALL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/complex_operand_packer_if.sv
// Stream bundle of the operand packer: beat input stream on the s_* side,
// packed vector output on the out_* side, plus status.
//   slave  : packer side (accepts beats, presents vectors)
//   master : environment side (sources beats, consumes vectors)
interface complex_operand_packer_if #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = complex_pkg::FP64_WIDTH
);
  import complex_pkg::*;

  localparam int unsigned LEN_W = $clog2(SIZE + 1);

  logic                                    s_valid_i;
  logic                                    s_ready_o;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0]      s_data_i;
  logic                                    s_last_i;
  logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0] operands_o;
  logic                                    out_valid_o;
  logic                                    out_ready_i;
  logic [LEN_W-1:0]                        len_o;
  logic                                    busy_o;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, out_ready_i,
    output s_ready_o, operands_o, out_valid_o, len_o, busy_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i, out_ready_i,
    input  s_ready_o, operands_o, out_valid_o, len_o, busy_o
  );

endinterface

// File: rtl/complex_operand_packer_operand_bank.sv
// One SIZE-deep beat store with a length register and zero-pad read mux.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (clears len)
//   i_clr         flush: clears len
//   i_we/i_waddr/i_wdata  beat write port
//   i_close/i_len latch the real beat count when the vector closes
//   o_operands    packed vector, elements at or beyond len read as +0.0
//   o_len         stored real beat count
module operand_bank
  import complex_pkg::*;
#(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = FP64_WIDTH,
  localparam int unsigned LEN_W = $clog2(SIZE + 1),
  localparam int unsigned CNT_W = $clog2(SIZE)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    i_clr,
  input  logic                                    i_we,
  input  logic [CNT_W-1:0]                        i_waddr,
  input  logic [NUM_OPERANDS-1:0][WIDTH-1:0]      i_wdata,
  input  logic                                    i_close,
  input  logic [LEN_W-1:0]                        i_len,
  output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0] o_operands,
  output logic [LEN_W-1:0]                        o_len
);

  logic [NUM_OPERANDS-1:0][WIDTH-1:0] r_mem [SIZE];
  logic [LEN_W-1:0]                   r_len;

  // Beat storage; data needs no reset because len masks stale entries
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Real beat count of the stored vector
  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) r_len <= '0;
    else if (i_close)   r_len <= i_len;
  end

  // Zero-pad mux: +0.0 leaves the downstream dot product unchanged
  always_comb begin
    o_operands = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
        o_operands[i*NUM_OPERANDS+k] = (LEN_W'(i) < r_len) ? r_mem[i][k]
                                                           : WIDTH'(FP64_ZERO);
      end
    end
  end

  assign o_len = r_len;

endmodule

// File: rtl/complex_operand_packer.sv
// Transmit side of the complex_matrix_mul operand interface. Packs SIZE
// beats into one operand vector using two ping-pong banks.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   flush_i  drops all buffered and partial data
//   bus      slave modport: beat stream in, packed vector out, len, busy
module complex_operand_packer
  import complex_pkg::*;
#(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = FP64_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  complex_operand_packer_if.slave  bus
);

  localparam int unsigned LEN_W = $clog2(SIZE + 1);
  localparam int unsigned CNT_W = $clog2(SIZE);

  wr_state_e        r_state, w_state_d;
  logic [1:0]       r_bank_full, w_bank_full_d;
  logic             r_wr_sel, w_wr_sel_d;
  logic             r_rd_sel, w_rd_sel_d;
  logic [CNT_W-1:0] r_wr_cnt, w_wr_cnt_d;

  logic [1:0]       w_we;
  logic [1:0]       w_close;
  logic [LEN_W-1:0] w_len;
  logic             w_s_ready;
  logic             w_accept;
  logic             w_out_valid;
  logic             w_release;
  logic             w_close_beat;

  logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0] w_ops      [2];
  logic [LEN_W-1:0]                        w_bank_len [2];

  // Handshake decode; outputs are forced low while reset is held
  assign w_s_ready    = !rst_i && (r_state == WR_FILL);
  assign w_accept     = w_s_ready && bus.s_valid_i;
  assign w_out_valid  = !rst_i && r_bank_full[r_rd_sel];
  assign w_release    = w_out_valid && bus.out_ready_i;
  assign w_close_beat = (r_wr_cnt == CNT_W'(SIZE - 1)) || bus.s_last_i;
  assign w_len        = LEN_W'(r_wr_cnt) + LEN_W'(1);

  // State and pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= WR_FILL;
      r_bank_full <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_wr_cnt    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_bank_full <= w_bank_full_d;
      r_wr_sel    <= w_wr_sel_d;
      r_rd_sel    <= w_rd_sel_d;
      r_wr_cnt    <= w_wr_cnt_d;
    end
  end

  // Next state: flush overrides; release and close act on different banks
  always_comb begin
    w_state_d     = r_state;
    w_bank_full_d = r_bank_full;
    w_wr_sel_d    = r_wr_sel;
    w_rd_sel_d    = r_rd_sel;
    w_wr_cnt_d    = r_wr_cnt;
    w_we          = '0;
    w_close       = '0;

    if (flush_i) begin
      w_bank_full_d = '0;
      w_wr_sel_d    = 1'b0;
      w_rd_sel_d    = 1'b0;
      w_wr_cnt_d    = '0;
    end else begin
      if (w_release) begin
        w_bank_full_d[r_rd_sel] = 1'b0;
        w_rd_sel_d              = !r_rd_sel;
      end
      if (w_accept) begin
        w_we[r_wr_sel] = 1'b1;
        if (w_close_beat) begin
          w_bank_full_d[r_wr_sel] = 1'b1;
          w_close[r_wr_sel]       = 1'b1;
          w_wr_sel_d              = !r_wr_sel;
          w_wr_cnt_d              = '0;
        end else begin
          w_wr_cnt_d = r_wr_cnt + CNT_W'(1);
        end
      end
    end

    // Stall whenever the bank about to be filled is still awaiting release
    w_state_d = w_bank_full_d[w_wr_sel_d] ? WR_STALL : WR_FILL;
  end

  // Ping-pong banks
  for (genvar b = 0; b < 2; b++) begin : g_bank
    operand_bank #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH)
    ) u_bank (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_clr      (flush_i),
      .i_we       (w_we[b]),
      .i_waddr    (r_wr_cnt),
      .i_wdata    (bus.s_data_i),
      .i_close    (w_close[b]),
      .i_len      (w_len),
      .o_operands (w_ops[b]),
      .o_len      (w_bank_len[b])
    );
  end

  assign bus.s_ready_o   = w_s_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.operands_o  = rst_i ? '0 : w_ops[r_rd_sel];
  assign bus.len_o       = rst_i ? '0 : w_bank_len[r_rd_sel];
  assign bus.busy_o      = !rst_i && ((|r_bank_full) || (r_wr_cnt != '0));

endmodule

// File: tb/tb_complex_operand_packer.sv
// Scoreboard bench for complex_operand_packer: stimulus pushes expected
// vectors, an independent monitor pops and compares on each accepted vector.
module tb_complex_operand_packer;
  import complex_pkg::*;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned NOPS  = NUM_OPERANDS;
  localparam int unsigned LEN_W = $clog2(SIZE + 1);

  typedef struct {
    logic [LEN_W-1:0]                   len;
    logic [SIZE*NOPS-1:0][FP64_WIDTH-1:0] ops;
    bit                                 dot;
    logic [63:0]                        dre;
    logic [63:0]                        dim;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  int   n_beats = 0;
  exp_t sb [$];

  complex_operand_packer_if #(.SIZE(SIZE), .WIDTH(FP64_WIDTH)) bus ();

  complex_operand_packer #(.SIZE(SIZE), .WIDTH(FP64_WIDTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic cplx_beat_t beat_fn(input int pat, input int tag, input int i);
    cplx_beat_t b;
    case (pat)
      0: begin
        b[OPERAND_A_RE] = $realtobits(1.0);
        b[OPERAND_A_IM] = $realtobits(0.0);
        b[OPERAND_B_RE] = $realtobits(real'(i + 1));
        b[OPERAND_B_IM] = $realtobits(0.0);
      end
      1: begin
        b[OPERAND_A_RE] = $realtobits(2.0);
        b[OPERAND_A_IM] = $realtobits(1.0);
        b[OPERAND_B_RE] = $realtobits(1.0);
        b[OPERAND_B_IM] = $realtobits(2.0);
      end
      default: begin
        for (int k = 0; k < int'(NOPS); k++)
          b[k] = 64'hA500_0000_0000_0000 | (64'(tag) << 16) | (64'(i) << 4) | 64'(k);
      end
    endcase
    return b;
  endfunction

  // Offer one beat at a negedge, return at the negedge after its handshake
  task automatic send(input cplx_beat_t d, input bit last);
    int t = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    bus.s_last_i  = last;
    while (!bus.s_ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=s_ready_o 0 want=1 within 500 cycles");
    end else begin
      @(negedge clk);
      n_beats++;
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
  endtask

  // Send n beats of a pattern; optionally raise out_ready before the final beat
  task automatic send_vector(input int pat, input int tag, input int n, input bit last,
                             input bit push, input bit dot, input real dre, input real dim,
                             input bit ready_before_last);
    exp_t e;
    e.ops = '0;
    e.len = LEN_W'(n);
    e.dot = dot;
    e.dre = $realtobits(dre);
    e.dim = $realtobits(dim);
    for (int i = 0; i < n; i++) begin
      cplx_beat_t b;
      b = beat_fn(pat, tag, i);
      for (int k = 0; k < int'(NOPS); k++) e.ops[i*NOPS+k] = b[k];
      if (ready_before_last && i == n - 1) bus.out_ready_i = 1'b1;
      send(b, last && (i == n - 1));
    end
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.s_ready_o), 64'd0);
    check({tag, "_busy"},  64'(bus.busy_o), 64'd0);
    check({tag, "_len"},   64'(bus.len_o), 64'd0);
    check({tag, "_ops_nonzero"}, 64'(bus.operands_o != '0), 64'd0);
  endtask

  // Monitor: every accepted vector must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!flush && bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vector got=len %0d want=no vector", bus.len_o);
        end else begin
          exp_t e;
          int   bad;
          real  re, im, ar, ai, br, bi;
          e = sb.pop_front();
          check("vec_len", 64'(bus.len_o), 64'(e.len));
          bad = -1;
          for (int j = SIZE*NOPS - 1; j >= 0; j--)
            if (bus.operands_o[j] !== e.ops[j]) bad = j;
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL vec_data word %0d got=%h want=%h", bad, bus.operands_o[bad], e.ops[bad]);
          end
          if (e.dot) begin
            re = 0.0;
            im = 0.0;
            for (int i = 0; i < int'(SIZE); i++) begin
              ar = $bitstoreal(bus.operands_o[i*NOPS+OPERAND_A_RE]);
              ai = $bitstoreal(bus.operands_o[i*NOPS+OPERAND_A_IM]);
              br = $bitstoreal(bus.operands_o[i*NOPS+OPERAND_B_RE]);
              bi = $bitstoreal(bus.operands_o[i*NOPS+OPERAND_B_IM]);
              re = re + (ar * br - ai * bi);
              im = im + (ar * bi + ai * br);
            end
            check("dot_re", $realtobits(re), e.dre);
            check("dot_im", $realtobits(im), e.dim);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=still running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    longint t0;
    int     t;
    rst             = 1'b1;
    flush           = 1'b0;
    bus.s_valid_i   = 1'b0;
    bus.s_last_i    = 1'b0;
    bus.s_data_i    = '0;
    bus.out_ready_i = 1'b0;

    // Reset state
    @(negedge clk);
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_exit_ready", 64'(bus.s_ready_o), 64'd1);
    check("rst_exit_valid", 64'(bus.out_valid_o), 64'd0);

    // Full vector: dot product 136 + j0
    bus.out_ready_i = 1'b1;
    send_vector(0, 0, 16, 1'b0, 1'b1, 1'b1, 136.0, 0.0, 1'b0);
    check("full_latency_valid", 64'(bus.out_valid_o), 64'd1);
    check("full_len", 64'(bus.len_o), 64'd16);
    check("full_op0_bre", bus.operands_o[2], $realtobits(1.0));
    check("full_op15_bre", bus.operands_o[4*15+2], $realtobits(16.0));

    // Short vector: 5 beats closed by s_last, dot product 0 + j25
    send_vector(1, 0, 5, 1'b1, 1'b1, 1'b1, 0.0, 25.0, 1'b0);
    check("short_latency_valid", 64'(bus.out_valid_o), 64'd1);
    check("short_len", 64'(bus.len_o), 64'd5);

    // Back-to-back: two vectors in 32 cycles, no input bubbles
    t0 = longint'($time);
    send_vector(2, 1, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
    send_vector(2, 2, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
    check("b2b_cycles", 64'((longint'($time) - t0) / 10), 64'd32);
    drain();

    // Backpressure: 40 beats with out_ready low, both banks fill
    bus.out_ready_i = 1'b0;
    t = n_beats;
    fork
      begin
        send_vector(2, 3, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
        send_vector(2, 4, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
        send_vector(2, 5, 8, 1'b1, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
      end
      begin
        int w = 0;
        while (n_beats < t + 32 && w < 200) begin
          @(negedge clk);
          #1;
          w++;
        end
        check("bp_reached_32", 64'(n_beats - t), 64'd32);
        check("bp_stall_ready", 64'(bus.s_ready_o), 64'd0);
        check("bp_busy", 64'(bus.busy_o), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("bp_still_stalled", 64'(bus.s_ready_o), 64'd0);
        check("bp_hold_valid", 64'(bus.out_valid_o), 64'd1);
        check("bp_hold_len", 64'(bus.len_o), 64'd16);
        bus.out_ready_i = 1'b1;
      end
    join
    drain();

    // Simultaneous close of bank B with release of bank A
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    send_vector(2, 6, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
    send_vector(2, 7, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b1);
    check("simul_next_valid", 64'(bus.out_valid_o), 64'd1);
    check("simul_ready", 64'(bus.s_ready_o), 64'd1);
    drain();

    // Flush with one bank full and 7 beats partial; offered beat is dropped
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    send_vector(2, 8, 16, 1'b0, 1'b0, 1'b0, 0.0, 0.0, 1'b0);
    send_vector(2, 9, 7, 1'b0, 1'b0, 1'b0, 0.0, 0.0, 1'b0);
    flush         = 1'b1;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = beat_fn(2, 99, 0);
    @(negedge clk);
    flush         = 1'b0;
    bus.s_valid_i = 1'b0;
    check("flush_valid", 64'(bus.out_valid_o), 64'd0);
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    check("flush_ready", 64'(bus.s_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    send_vector(2, 10, 16, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
    check("flush_clean_len", 64'(bus.len_o), 64'd16);
    drain();

    // Reset mid-fill: old partial beats never reappear
    send_vector(2, 11, 9, 1'b0, 1'b0, 1'b0, 0.0, 0.0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst1");
    @(negedge clk);
    check_reset_outputs("rst2");
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 64'(bus.s_ready_o), 64'd1);
    check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
    check("rst_mid_valid", 64'(bus.out_valid_o), 64'd0);
    send_vector(2, 12, 3, 1'b1, 1'b1, 1'b0, 0.0, 0.0, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
